serial_mag_cmp: RTL
===================

SERIAL_MAG_CMP -- requirements
Module: serial_mag_cmp

Interface
REQ-001 Parameter N, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request a new comparison; sampled only in IDLE.
REQ-005 chave  input  1  mode select, sampled with start: 0 = report a<b, 1 = report a>b.
REQ-006 bit_valid  input  1  a_bit/b_bit carry a valid operand bit this cycle.
REQ-007 a_bit  input  1  operand A serial bit, MSB first.
REQ-008 b_bit  input  1  operand B serial bit, MSB first.
REQ-009 busy  output  1  high in RUN state.
REQ-010 done  output  1  one-cycle pulse, high in DONE state.
REQ-011 result  output  1  selected comparison outcome; valid while done=1.
REQ-012 eq  output  1  operands equal; valid while done=1.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 SHALL latch chave into mode_q, clear gt_q, lt_q and bit counter cnt, and enter RUN next cycle.
REQ-015 IDLE: start=0 SHALL keep the FSM in IDLE with all state held.
REQ-016 RUN: a cycle with bit_valid=1 SHALL accept one bit pair and increment cnt by 1.
REQ-017 RUN: a cycle with bit_valid=0 SHALL hold cnt, gt_q and lt_q unchanged (stall, no timeout).
REQ-018 Decision: on an accepted pair with gt_q=0 and lt_q=0, a_bit=1,b_bit=0 SHALL set gt_q; a_bit=0,b_bit=1 SHALL set lt_q.
REQ-019 Once gt_q or lt_q is set it SHALL remain set until the next start; later bits SHALL not alter it.
REQ-020 gt_q and lt_q SHALL never both be 1.
REQ-021 cnt SHALL be ceil(log2(N+1)) bits wide; when the N-th pair is accepted the FSM SHALL enter DONE next cycle.
REQ-022 Bits with bit_valid=1 presented outside RUN SHALL be ignored.
REQ-023 start asserted during RUN or DONE SHALL be ignored; it is not queued.
REQ-024 DONE: done=1, result = mode_q ? gt_q : lt_q, eq = ~gt_q & ~lt_q, for exactly one cycle, then IDLE.
REQ-025 result and eq SHALL be 0 in every state other than DONE.
REQ-026 Latency: from the cycle start is sampled, done SHALL rise N+1 cycles later when bit_valid is held at 1.
REQ-027 A new start sampled in the IDLE cycle right after DONE SHALL be honoured (back-to-back operation, one idle cycle minimum).
REQ-028 chave changes after start is sampled SHALL not affect the running comparison.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, cnt=0, gt_q=0, lt_q=0, mode_q=0, busy=0, done=0, result=0, eq=0, without waiting for clk.
REQ-030 Reset asserted mid-RUN or in DONE SHALL abort the comparison with no done pulse.
REQ-031 After rst_n deasserts, the first rising edge SHALL evaluate start normally.

Verification
REQ-032 N=8, chave=0, A=0x35, B=0x3A streamed with bit_valid=1 -> done 9 cycles after start, result=1, eq=0.
REQ-033 N=8, chave=1, A=0x35, B=0x3A -> result=0, eq=0; same operands with A and B swapped -> result=1.
REQ-034 N=8, either chave, A=B=0xA5 -> result=0, eq=1; also A=B=0x00 and A=B=0xFF -> eq=1.
REQ-035 N=8, chave=1, A=0x80, B=0x7F with bit_valid deasserted for 3 random cycles -> done 12 cycles after start, result=1; first-bit decision holds despite later bits favouring B.
REQ-036 Start pulsed at RUN bit 4, then rst_n pulsed low at bit 6 -> no done pulse, all outputs 0 immediately; next start completes normally.
REQ-037 Exhaustive N=2: all 16 (A,B) pairs x both chave values, back-to-back starts -> result equals A<B (chave=0) or A>B (chave=1), eq equals A==B.

Source files
------------

// File: rtl/serial_mag_cmp.sv
// rtl/serial_mag_cmp.sv - MSB-first bit-serial magnitude comparator
//
// Compares two N-bit operands streamed one bit pair per accepted cycle,
// most significant bit first. The first differing bit pair decides the
// outcome; every later pair is ignored.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a comparison (sampled only in IDLE)
//   chave      mode, sampled with start: 0 = report a<b, 1 = report a>b
//   bit_valid  a_bit/b_bit hold a valid operand bit pair this cycle
//   a_bit      operand A serial bit, MSB first
//   b_bit      operand B serial bit, MSB first
//   busy       high while bits are being consumed (RUN)
//   done       one-cycle completion pulse (DONE)
//   result     selected comparison outcome, qualified by done
//   eq         operands equal, qualified by done

`timescale 1ns/1ps

module serial_mag_cmp #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic chave,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic result,
  output logic eq
);

  localparam int CW = $clog2(N + 1);
  // Counter value while the N-th pair is being presented.
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            gt_q, gt_d;
  logic            lt_q, lt_d;
  logic            mode_q, mode_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    mode_d  = mode_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = chave;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (bit_valid) begin
          cnt_d = cnt_q + CW'(1);
          // Only the first differing pair decides; once either flag is
          // set the verdict is frozen, which also keeps gt/lt exclusive.
          if (!gt_q && !lt_q) begin
            gt_d = a_bit & ~b_bit;
            lt_d = ~a_bit & b_bit;
          end
          if (cnt_q == LAST_CNT) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy   = (state_q == S_RUN);
    done   = (state_q == S_DONE);
    result = done & (mode_q ? gt_q : lt_q);
    eq     = done & ~gt_q & ~lt_q;
  end

endmodule
